// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_unit_pkg : widths, reset PC default and prefetch entry layout
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_unit_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo : synchronous DEPTH-entry prefetch FIFO, flush beats push
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit : instruction fetch with prefetch buffer and redirect flush
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = fetch_unit_pkg::DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc
);

  import fetch_unit_pkg::*;

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight_kill;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_occupancy;
  logic              w_issue;
  logic              w_capture;
  logic              w_pop;
  fetch_entry_t      w_push_data;
  fetch_entry_t      w_head;

  // A same-cycle pop is not credited, so a full buffer costs one bubble on resume.
  assign w_occupancy = w_count + CNT_W'(r_inflight);
  assign w_issue     = !rst && !redirect && (w_occupancy < CNT_W'(DEPTH));
  assign w_capture   = r_inflight && !r_inflight_kill && !redirect;
  assign w_pop       = out_valid && out_ready;
  assign w_push_data = '{pc: r_inflight_pc, instr: mem_din};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc      <= RESET_PC;
      r_inflight      <= 1'b0;
      r_inflight_pc   <= '0;
      r_inflight_kill <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_kill <= redirect;
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 16'd1;
      end
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (w_capture),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (w_count)
  );

  assign mem_ren   = w_issue;
  assign mem_wen   = 1'b0;
  assign mem_addr  = r_fetch_pc;
  assign out_valid = (w_count != '0);
  assign out_instr = out_valid ? w_head.instr : '0;
  assign out_pc    = out_valid ? w_head.pc    : '0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit : directed and randomized checks of fetch_unit against a
//                 program-order stream model; Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        mem_ren;
  logic        mem_wen;
  logic [15:0] mem_addr;
  logic [15:0] mem_din = 16'h0000;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;

  logic [15:0] ram [65536];
  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_ren     (mem_ren),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  // Read-only ram: address sampled at the edge, data held for the next cycle.
  always @(posedge clk) if (mem_ren) mem_din <= ram[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = ready;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp_instr [3];
    ram[0] = 16'h00FF; ram[1] = 16'h0001; ram[2] = 16'h1234;
    exp_instr[0] = 16'h00FF; exp_instr[1] = 16'h0001; exp_instr[2] = 16'h1234;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || mem_ren !== 1'b0 || mem_wen !== 1'b0 || out_pc !== 16'h0 || out_instr !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: valid=%b ren=%b wen=%b pc=%h instr=%h, want all zero",
               out_valid, mem_ren, mem_wen, out_pc, out_instr);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++;
        if (mem_ren !== 1'b1 || mem_addr !== RESET_PC) begin
          bad++;
          $display("FAIL reset_first_issue: ren=%b addr=%h, want 1 %h", mem_ren, mem_addr, RESET_PC);
        end
      end
      total++;
      if (out_valid !== (c >= 2)) begin
        bad++;
        $display("FAIL reset_latency c%0d: valid=%b, want %b", c, out_valid, (c >= 2));
      end else if (c >= 2 && (out_pc !== 16'(c - 2) || out_instr !== exp_instr[c-2])) begin
        bad++;
        $display("FAIL reset_stream c%0d: pc=%h instr=%h, want %h %h", c, out_pc, out_instr, 16'(c - 2), exp_instr[c-2]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int          issued   = 0;
    int          accepted = 0;
    logic [15:0] exp_pc   = RESET_PC;
    do_reset(1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_ren === 1'b1) begin
        total++;
        if (mem_addr !== 16'(issued)) begin
          bad++;
          $display("FAIL bp_issue_addr: addr=%h, want %h", mem_addr, 16'(issued));
        end
        issued++;
      end
      if (c >= 2) begin
        total++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0 || out_instr !== ram[0]) begin
          bad++;
          $display("FAIL bp_head_hold c%0d: valid=%b pc=%h instr=%h, want 1 0000 %h", c, out_valid, out_pc, out_instr, ram[0]);
        end
      end
      tick();
    end
    total++;
    if (issued != DEPTH) begin
      bad++;
      $display("FAIL bp_issue_count: issued=%0d, want %0d", issued, DEPTH);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && accepted < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++;
        if (mem_ren !== 1'b0) begin
          bad++;
          $display("FAIL bp_no_credit: ren=%b, want 0", mem_ren);
        end
      end
      if (c == 1) begin
        total++;
        if (mem_ren !== 1'b1 || mem_addr !== 16'h0004) begin
          bad++;
          $display("FAIL bp_resume: ren=%b addr=%h, want 1 0004", mem_ren, mem_addr);
        end
      end
      if (out_valid === 1'b1) begin
        total++;
        if (out_pc !== exp_pc || out_instr !== ram[exp_pc]) begin
          bad++;
          $display("FAIL bp_drain: pc=%h instr=%h, want %h %h", out_pc, out_instr, exp_pc, ram[exp_pc]);
        end
        exp_pc++;
        accepted++;
      end
      tick();
    end
    total++;
    if (accepted != 6) begin
      bad++;
      $display("FAIL bp_drain_count: accepted=%0d, want 6", accepted);
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (4) tick();
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0 || mem_ren !== 1'b0) begin
      bad++;
      $display("FAIL redir_cycle: valid=%b pc=%h ren=%b, want 1 0000 0", out_valid, out_pc, mem_ren);
    end
    tick();
    redirect = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || mem_ren !== 1'b1 || mem_addr !== 16'h0040) begin
      bad++;
      $display("FAIL redir_r1: valid=%b ren=%b addr=%h, want 0 1 0040", out_valid, mem_ren, mem_addr);
    end
    tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_r2: valid=%b, want 0", out_valid);
    end
    tick();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0040 + 16'(k) || out_instr !== ram[16'h0040 + 16'(k)]) begin
        bad++;
        $display("FAIL redir_stream k%0d: valid=%b pc=%h instr=%h, want 1 %h %h", k, out_valid, out_pc, out_instr,
                 16'h0040 + 16'(k), ram[16'h0040 + 16'(k)]);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc;
    int          found_at = -1;
    ram[16'hFFFE] = 16'hAAAA; ram[16'hFFFF] = 16'hBBBB; ram[16'h0000] = 16'h00FF;
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    for (int n = 0; n < 8 && found_at < 0; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) found_at = n;
      else tick();
    end
    total++;
    if (found_at != 2) begin
      bad++;
      $display("FAIL wrap_latency: first valid at R+%0d, want R+3", found_at + 1);
    end
    if (found_at >= 0) begin
      exp_pc = 16'hFFFE;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) begin
          tick();
          @(negedge clk);
        end
        total++;
        if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== ram[exp_pc]) begin
          bad++;
          $display("FAIL wrap_stream k%0d: valid=%b pc=%h instr=%h, want 1 %h %h", k, out_valid, out_pc, out_instr, exp_pc, ram[exp_pc]);
        end
        exp_pc = exp_pc + 16'd1;
      end
      tick();
    end
  endtask

  task automatic test_toggle();
    logic [15:0] exp_pc = RESET_PC;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_pc = '0;
    logic [15:0] prev_instr = '0;
    int          accepted = 0;
    do_reset(1'b1);
    for (int c = 0; c < 40; c++) begin
      out_ready = (c % 2 == 0);
      @(negedge clk);
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || out_pc !== prev_pc || out_instr !== prev_instr) begin
          bad++;
          $display("FAIL toggle_stable c%0d: valid=%b pc=%h instr=%h, want 1 %h %h", c, out_valid, out_pc, out_instr, prev_pc, prev_instr);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        if (out_pc !== exp_pc || out_instr !== ram[exp_pc]) begin
          bad++;
          $display("FAIL toggle_order c%0d: pc=%h instr=%h, want %h %h", c, out_pc, out_instr, exp_pc, ram[exp_pc]);
        end
        exp_pc++;
        accepted++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_pc    = out_pc;
      prev_instr = out_instr;
      tick();
    end
    total++;
    if (accepted < 15) begin
      bad++;
      $display("FAIL toggle_throughput: accepted=%0d, want >= 15", accepted);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    repeat (4) tick();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (mem_ren !== 1'b0) begin
      bad++;
      $display("FAIL midrst_ren: ren=%b, want 0", mem_ren);
    end
    tick();
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || mem_ren !== 1'b1 || mem_addr !== RESET_PC) begin
      bad++;
      $display("FAIL midrst_restart: valid=%b ren=%b addr=%h, want 0 1 %h", out_valid, mem_ren, mem_addr, RESET_PC);
    end
    tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_stale: valid=%b pc=%h, want 0", out_valid, out_pc);
    end
    tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_instr !== ram[RESET_PC]) begin
      bad++;
      $display("FAIL midrst_first: valid=%b pc=%h instr=%h, want 1 %h %h", out_valid, out_pc, out_instr, RESET_PC, ram[RESET_PC]);
    end
    tick();
  endtask

  // Reference: decode must see consecutive addresses from the last restart point.
  task automatic test_random();
    logic [15:0] exp_pc = RESET_PC;
    int          gap = 0;
    int          accepted = 0;
    do_reset(1'b1);
    for (int c = 0; c < 400; c++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom);
      rst         = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      total++;
      if (mem_wen !== 1'b0) begin
        bad++;
        $display("FAIL rand_wen c%0d: wen=%b, want 0", c, mem_wen);
      end
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        if (out_pc !== exp_pc || out_instr !== ram[exp_pc]) begin
          bad++;
          $display("FAIL rand_order c%0d: pc=%h instr=%h, want %h %h", c, out_pc, out_instr, exp_pc, ram[exp_pc]);
        end
        exp_pc++;
        accepted++;
      end
      gap = (out_valid === 1'b1) ? 0 : gap + 1;
      total++;
      if (gap > 2) begin
        bad++;
        $display("FAIL rand_bubble c%0d: empty for %0d cycles, want <= 2", c, gap);
      end
      if (rst) begin
        exp_pc = RESET_PC; gap = 0;
      end else if (redirect) begin
        exp_pc = redirect_pc; gap = 0;
      end
      tick();
    end
    rst = 1'b0; redirect = 1'b0;
    total++;
    if (accepted < 100) begin
      bad++;
      $display("FAIL rand_throughput: accepted=%0d, want >= 100", accepted);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 16'($urandom);
    test_reset();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_toggle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
